mac_accumulator: RTL



---
 rtl/mac_accumulator.sv | 115 +++++++++++
 1 files changed

// File: rtl/mac_accumulator.sv
// mac_accumulator: sums num_terms signed products from the multiplier,
// then shifts and saturates one result word for the next layer.
module mac_accumulator #(
    parameter int IN_WIDTH  = 32,
    parameter int CNT_WIDTH = 10,
    parameter int ACC_WIDTH = 42,
    parameter int OUT_SHIFT = 0,
    parameter int OUT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 arst,
    input  logic                 start,
    input  logic [CNT_WIDTH-1:0] num_terms,
    input  logic [IN_WIDTH-1:0]  prod_in,
    input  logic                 prod_valid,
    output logic                 prod_ready,
    output logic [OUT_WIDTH-1:0] out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 overflow,
    output logic                 busy
);

    if (ACC_WIDTH < IN_WIDTH + CNT_WIDTH) begin : g_width_chk
        $error("mac_accumulator: ACC_WIDTH must be >= IN_WIDTH+CNT_WIDTH");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    localparam logic signed [ACC_WIDTH-1:0] OMAX =
        {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] OMIN =
        {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    state_t                        state;
    logic signed [ACC_WIDTH-1:0]   acc;
    logic        [CNT_WIDTH-1:0]   cnt;
    logic        [CNT_WIDTH-1:0]   nterms;
    logic        [CNT_WIDTH-1:0]   last;
    logic signed [ACC_WIDTH-1:0]   ext;
    logic signed [ACC_WIDTH-1:0]   sum;
    logic signed [ACC_WIDTH-1:0]   res;

    // Handshake flags decode straight from the state register.
    assign prod_ready = (state == ACCUM);
    assign out_valid  = (state == DONE);
    assign busy       = (state != IDLE);

    always_comb begin
        last = nterms - ONE;
        ext  = {{(ACC_WIDTH-IN_WIDTH){prod_in[IN_WIDTH-1]}}, prod_in};
        sum  = acc + ext;
        res  = sum >>> OUT_SHIFT;
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state    <= IDLE;
            acc      <= '0;
            cnt      <= '0;
            nterms   <= '0;
            out      <= '0;
            overflow <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (num_terms != '0) begin
                            state  <= ACCUM;
                            acc    <= '0;
                            cnt    <= '0;
                            nterms <= num_terms;
                        end else begin
                            state    <= DONE;
                            out      <= '0;
                            overflow <= 1'b0;
                        end
                    end
                end
                ACCUM: begin
                    if (prod_valid) begin
                        acc <= sum;
                        cnt <= cnt + ONE;
                        if (cnt == last) begin
                            state <= DONE;
                            if (res > OMAX) begin
                                out      <= OMAX[OUT_WIDTH-1:0];
                                overflow <= 1'b1;
                            end else if (res < OMIN) begin
                                out      <= OMIN[OUT_WIDTH-1:0];
                                overflow <= 1'b1;
                            end else begin
                                out      <= res[OUT_WIDTH-1:0];
                                overflow <= 1'b0;
                            end
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
